// File: rtl/sram_bist_sequencer_if.sv
// sram_bist_sequencer_if -- request/response and BIST broadcast bus of the SRAM BIST sequencer (rev 1.0)
`default_nettype none

interface sram_bist_sequencer_if #(
   parameter int OP_WIDTH       = 4,
   parameter int REQ_DATA_WIDTH = 192,
   parameter int RES_DATA_WIDTH = 256
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [7:0]                req_id;
   logic [7:0]                req_bsel;
   logic [15:0]               req_addr;
   logic [REQ_DATA_WIDTH-1:0] req_wdata;
   logic                      rsp_valid;
   logic [RES_DATA_WIDTH-1:0] rsp_rdata;
   logic [OP_WIDTH-1:0]       bist_command;
   logic [3:0]                bist_data;
   logic [3:0]                bist_data_in;
   logic                      busy;

   modport master (
      output req_valid, req_write, req_id, req_bsel, req_addr, req_wdata, bist_data_in,
      input  req_ready, rsp_valid, rsp_rdata, bist_command, bist_data, busy
   );

   modport slave (
      input  req_valid, req_write, req_id, req_bsel, req_addr, req_wdata, bist_data_in,
      output req_ready, rsp_valid, rsp_rdata, bist_command, bist_data, busy
   );
endinterface

`default_nettype wire

// File: rtl/sram_bist_sequencer.sv
// sram_bist_sequencer -- turns one parallel debug request into the nibble-serial BIST command/data stream (rev 1.0)
`default_nettype none

module sram_bist_sequencer #(
   parameter int                  OP_WIDTH         = 4,
   parameter logic [OP_WIDTH-1:0] OP_NOP           = OP_WIDTH'(0),
   parameter logic [OP_WIDTH-1:0] OP_SHIFT_ID      = OP_WIDTH'(1),
   parameter logic [OP_WIDTH-1:0] OP_SHIFT_BSEL    = OP_WIDTH'(2),
   parameter logic [OP_WIDTH-1:0] OP_SHIFT_ADDRESS = OP_WIDTH'(3),
   parameter logic [OP_WIDTH-1:0] OP_SHIFT_DATA    = OP_WIDTH'(4),
   parameter logic [OP_WIDTH-1:0] OP_READ          = OP_WIDTH'(5),
   parameter int                  REQ_DATA_WIDTH   = 192,
   parameter int                  RES_DATA_WIDTH   = 256
) (
   input  wire logic          clk,
   input  wire logic          rst,
   sram_bist_sequencer_if.slave bus
);

   // The first ID nibble goes straight to the bus on acceptance, so the
   // outgoing shift register only holds what follows it.
   localparam int         SH_W    = 8 + 8 + 16 + REQ_DATA_WIDTH - 4;
   localparam logic [5:0] TX_LAST = 6'(REQ_DATA_WIDTH / 4 - 1);
   localparam logic [5:0] RX_LAST = 6'(RES_DATA_WIDTH / 4 - 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_ID    = 4'd1,
      S_BSEL  = 4'd2,
      S_ADDR  = 4'd3,
      S_TX    = 4'd4,
      S_GAP_W = 4'd5,
      S_RDREQ = 4'd6,
      S_GAP_R = 4'd7,
      S_RX    = 4'd8,
      S_RESP  = 4'd9
   } state_t;

   state_t                    state;
   logic [5:0]                cnt;
   logic                      is_write;
   logic [SH_W-1:0]           tx_sreg;
   logic [RES_DATA_WIDTH-1:0] rx_sreg;
   logic                      ready_q;
   logic                      busy_q;
   logic                      rsp_valid_q;
   logic [RES_DATA_WIDTH-1:0] rsp_rdata_q;
   logic [OP_WIDTH-1:0]       command_q;
   logic [3:0]                data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= 6'd0;
         is_write    <= 1'b0;
         tx_sreg     <= '0;
         rx_sreg     <= '0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         command_q   <= OP_NOP;
         data_q      <= 4'h0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  state     <= S_ID;
                  cnt       <= 6'd0;
                  is_write  <= bus.req_write;
                  tx_sreg   <= {bus.req_id[3:0], bus.req_bsel, bus.req_addr, bus.req_wdata};
                  rx_sreg   <= '0;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  command_q <= OP_SHIFT_ID;
                  data_q    <= bus.req_id[7:4];
               end
            end
            S_ID: begin
               data_q  <= tx_sreg[SH_W-1 -: 4];
               tx_sreg <= tx_sreg << 4;
               if (cnt == 6'd1) begin
                  state     <= S_BSEL;
                  cnt       <= 6'd0;
                  command_q <= OP_SHIFT_BSEL;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            S_BSEL: begin
               data_q  <= tx_sreg[SH_W-1 -: 4];
               tx_sreg <= tx_sreg << 4;
               if (cnt == 6'd1) begin
                  state     <= S_ADDR;
                  cnt       <= 6'd0;
                  command_q <= OP_SHIFT_ADDRESS;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            S_ADDR: begin
               data_q  <= tx_sreg[SH_W-1 -: 4];
               tx_sreg <= tx_sreg << 4;
               if (cnt == 6'd3) begin
                  cnt <= 6'd0;
                  if (is_write) begin
                     state     <= S_TX;
                     command_q <= OP_SHIFT_DATA;
                  end else begin
                     state     <= S_RDREQ;
                     command_q <= OP_READ;
                     data_q    <= 4'h0;
                  end
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            S_TX: begin
               if (cnt == TX_LAST) begin
                  state       <= S_GAP_W;
                  cnt         <= 6'd0;
                  command_q   <= OP_NOP;
                  data_q      <= 4'h0;
                  rsp_valid_q <= 1'b1;
               end else begin
                  data_q  <= tx_sreg[SH_W-1 -: 4];
                  tx_sreg <= tx_sreg << 4;
                  cnt     <= cnt + 6'd1;
               end
            end
            S_GAP_W: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            S_RDREQ: begin
               state     <= S_GAP_R;
               command_q <= OP_NOP;
            end
            S_GAP_R: begin
               state     <= S_RX;
               command_q <= OP_SHIFT_DATA;
               data_q    <= 4'h0;
            end
            S_RX: begin
               rx_sreg <= {rx_sreg[RES_DATA_WIDTH-5:0], bus.bist_data_in};
               if (cnt == RX_LAST) begin
                  state       <= S_RESP;
                  cnt         <= 6'd0;
                  command_q   <= OP_NOP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= {rx_sreg[RES_DATA_WIDTH-5:0], bus.bist_data_in};
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            S_RESP: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               cnt       <= 6'd0;
               ready_q   <= 1'b1;
               busy_q    <= 1'b0;
               command_q <= OP_NOP;
               data_q    <= 4'h0;
            end
         endcase
      end
   end

   assign bus.req_ready    = ready_q;
   assign bus.busy         = busy_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_rdata    = rsp_rdata_q;
   assign bus.bist_command = command_q;
   assign bus.bist_data    = data_q;

endmodule

`default_nettype wire
